// File: rtl/station_multi_lane_rr_if.sv
// Handshake bundle for the multi-lane engine station: per-lane token
// input/output streams plus the engine tap in both directions.
interface station_multi_lane_rr_if #(
   parameter int PC_WIDTH   = 8,
   parameter int CC_ID_BITS = 2,
   parameter int NUM_LANES  = 2
);
   localparam int W = PC_WIDTH + CC_ID_BITS;

   logic [NUM_LANES*W-1:0] lane_in_data;
   logic [NUM_LANES-1:0]   lane_in_valid;
   logic [NUM_LANES-1:0]   lane_in_ready;
   logic [NUM_LANES*W-1:0] lane_out_data;
   logic [NUM_LANES-1:0]   lane_out_valid;
   logic [NUM_LANES-1:0]   lane_out_ready;
   logic [W-1:0]           eng_in_data;
   logic                   eng_in_valid;
   logic                   eng_in_ready;
   logic [W-1:0]           eng_out_data;
   logic                   eng_out_valid;
   logic                   eng_out_ready;

   // Environment side: feeds lanes, drains lanes, plays the engine.
   modport master (
      output lane_in_data, lane_in_valid, input lane_in_ready,
      input lane_out_data, lane_out_valid, output lane_out_ready,
      input eng_in_data, eng_in_valid, output eng_in_ready,
      output eng_out_data, eng_out_valid, input eng_out_ready
   );

   // Station side.
   modport slave (
      input lane_in_data, lane_in_valid, output lane_in_ready,
      output lane_out_data, lane_out_valid, input lane_out_ready,
      output eng_in_data, eng_in_valid, input eng_in_ready,
      input eng_out_data, eng_out_valid, output eng_out_ready
   );
endinterface

// File: rtl/station_multi_lane_rr.sv
// Multi-lane engine station: per-lane FIFOs, round-robin offer of lane
// heads to a shared engine, engine results injected into the
// least-occupied lane, per-cc_id occupancy tracking for status.
module station_multi_lane_rr #(
   parameter int PC_WIDTH        = 8,
   parameter int CC_ID_BITS      = 2,
   parameter int NUM_LANES       = 2,
   parameter int FIFO_DEPTH_BITS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   station_multi_lane_rr_if.slave     bus,
   input  logic                       engine_running,
   input  logic [(1<<CC_ID_BITS)-1:0] engine_elaborating,
   output logic [(1<<CC_ID_BITS)-1:0] elaborating_chars,
   output logic                       station_running,
   output logic                       station_full
);
   localparam int W   = PC_WIDTH + CC_ID_BITS;
   localparam int D   = 1 << FIFO_DEPTH_BITS;
   localparam int NC  = 1 << CC_ID_BITS;
   localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CW  = FIFO_DEPTH_BITS + $clog2(NUM_LANES) + 1;
   localparam int CTW = FIFO_DEPTH_BITS + 1;

   logic [W-1:0]               mem   [NUM_LANES][D];
   logic [FIFO_DEPTH_BITS-1:0] wptr  [NUM_LANES];
   logic [FIFO_DEPTH_BITS-1:0] rptr  [NUM_LANES];
   logic [CTW-1:0]             count [NUM_LANES];
   logic [CW-1:0]              cnt   [NC];
   logic [LW-1:0]              gp;

   logic [W-1:0]         head  [NUM_LANES];
   logic [W-1:0]         wdata [NUM_LANES];
   logic [NUM_LANES-1:0] ne, full, pop, push, lov, lir;
   logic [LW-1:0]        g, inj;
   logic                 any_ne, eng_xfer, inj_wr;
   int                   cnt_sum [NC];

   // FIFO head/level decode from registered state.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         head[i] = mem[i][rptr[i]];
         ne[i]   = (count[i] != '0);
         full[i] = (count[i] == CTW'(D));
      end
      any_ne = |ne;
   end

   // Round-robin pick: first non-empty lane at or after gp, with wrap.
   always_comb begin
      int idx;
      idx = 0;
      g   = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         idx = (int'(gp) + k) % NUM_LANES;
         if (ne[idx]) g = LW'(idx);
      end
   end

   // Injection target: smallest registered count, lowest index on ties.
   always_comb begin
      inj = '0;
      for (int i = 1; i < NUM_LANES; i++)
         if (count[i] < count[inj]) inj = LW'(i);
   end

   // Handshakes; the engine token only leaves a lane's output when the
   // engine really takes it, so no token is lost or duplicated.
   always_comb begin
      lov    = '0;
      lir    = '0;
      pop    = '0;
      push   = '0;
      eng_xfer = rst && any_ne && bus.eng_in_ready;
      for (int i = 0; i < NUM_LANES; i++) begin
         lov[i] = rst && ne[i] && !(any_ne && g == LW'(i) && bus.eng_in_ready);
         pop[i] = (lov[i] && bus.lane_out_ready[i]) || (eng_xfer && g == LW'(i));
      end
      inj_wr = 1'b0;
      bus.eng_out_ready = rst && (!full[inj] || pop[inj]);
      inj_wr = bus.eng_out_valid && bus.eng_out_ready;
      for (int i = 0; i < NUM_LANES; i++) begin
         lir[i]   = rst && (!full[i] || pop[i]) && !(bus.eng_out_valid && inj == LW'(i));
         push[i]  = (bus.lane_in_valid[i] && lir[i]) || (inj_wr && inj == LW'(i));
         wdata[i] = (inj_wr && inj == LW'(i)) ? bus.eng_out_data : bus.lane_in_data[i*W +: W];
      end
      bus.lane_out_valid = lov;
      bus.lane_in_ready  = lir;
      bus.eng_in_valid   = rst && any_ne;
      bus.eng_in_data    = head[g];
      for (int i = 0; i < NUM_LANES; i++) bus.lane_out_data[i*W +: W] = head[i];
   end

   // Per-cc_id occupancy next value: all lane writes in, all pops out.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         cnt_sum[c] = int'(cnt[c]);
         for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i] && wdata[i][W-1 -: CC_ID_BITS] == CC_ID_BITS'(c)) cnt_sum[c] = cnt_sum[c] + 1;
            if (pop[i]  && head[i][W-1 -: CC_ID_BITS]  == CC_ID_BITS'(c)) cnt_sum[c] = cnt_sum[c] - 1;
         end
      end
   end

   // Status outputs.
   always_comb begin
      for (int c = 0; c < NC; c++)
         elaborating_chars[c] = (cnt[c] != '0) || engine_elaborating[c];
      station_running = any_ne || engine_running;
      station_full    = &full;
   end

   // FIFO storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++)
         if (push[i]) mem[i][wptr[i]] <= wdata[i];
   end

   // Pointers, levels, occupancy counters and grant pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            count[i] <= '0;
         end
         for (int c = 0; c < NC; c++) cnt[c] <= '0;
         gp <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) wptr[i] <= wptr[i] + 1'b1;
            if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
            count[i] <= count[i] + CTW'(push[i]) - CTW'(pop[i]);
            assert (!(push[i] && full[i] && !pop[i]));
         end
         for (int c = 0; c < NC; c++) begin
            assert (cnt_sum[c] >= 0 && cnt_sum[c] <= NUM_LANES * D);
            cnt[c] <= CW'(cnt_sum[c]);
         end
         if (eng_xfer) gp <= (g == LW'(NUM_LANES - 1)) ? '0 : g + 1'b1;
      end
   end
endmodule

// File: doc/station_multi_lane_rr.md
Name: station_multi_lane_rr

Overview:
- Generalised engine station: NUM_LANES pass-through token lanes, each buffered by a FIFO, share one engine tap.
- Lane heads are offered to the engine under round-robin arbitration; tokens the engine does not take continue out of their lane to the next station.
- Tokens produced by the engine are injected into the least-occupied lane.
- Per-cc_id occupancy tracking drives elaborating_chars; the station also reports running and full status.
- Token format everywhere: {cc_id[CC_ID_BITS], pc[PC_WIDTH]}, W = PC_WIDTH+CC_ID_BITS.

Parameters:
- PC_WIDTH, 8, program-counter width.
- CC_ID_BITS, 2, cc_id width; 2**CC_ID_BITS character slots.
- NUM_LANES, 2, number of lanes, >=1.
- FIFO_DEPTH_BITS, 2, log2 of per-lane FIFO depth (D = 4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the rising edge of clk).
- lane_in_data  in  NUM_LANES*W  incoming token per lane; lane i at bits [i*W +: W].
- lane_in_valid  in  NUM_LANES  per-lane valid.
- lane_in_ready  out  NUM_LANES  per-lane ready.
- lane_out_data  out  NUM_LANES*W  outgoing token per lane.
- lane_out_valid  out  NUM_LANES  outgoing valid.
- lane_out_ready  in  NUM_LANES  downstream ready.
- eng_in_data  out  W  token to engine.
- eng_in_valid  out  1  token to engine valid.
- eng_in_ready  in  1  engine accepts.
- eng_out_data  in  W  token from engine.
- eng_out_valid  in  1  token from engine valid.
- eng_out_ready  out  1  station accepts engine token.
- engine_running  in  1  engine busy.
- engine_elaborating  in  2**CC_ID_BITS  cc_ids held inside the engine.
- elaborating_chars  out  2**CC_ID_BITS  cc_ids present anywhere in station or engine.
- station_running  out  1  any token in the station or engine.
- station_full  out  1  all lane FIFOs full.

Behaviour:
- Handshake: a transfer occurs on a cycle with valid&&ready. Valid must not depend combinationally on ready.
- FIFOs: one per lane, depth D, registered. A token written at edge t is visible at the head from cycle t+1 (no bypass). Simultaneous push and pop on a full FIFO is allowed: the pop frees a slot the same cycle.
- Injection select: inj = lane with the smallest registered count; ties go to the lowest index. eng_out_ready = !full[inj] || pop[inj].
- Injection priority: when eng_out_valid is high, lane_in_ready[inj] = 0 that cycle; the engine token is written to lane inj.
- Normal lane ready: lane_in_ready[i] = !full[i] || pop[i], for every lane other than an active injection target.
- Arbitration: the grant pointer gp (0..NUM_LANES-1) selects the first non-empty lane scanning from gp upward with wrap; that lane is g.
  - eng_in_valid = any lane non-empty; eng_in_data = head[g].
  - On an eng_in transfer: pop lane g, then gp <= (g+1) mod NUM_LANES.
  - With no engine transfer, gp holds.
- Lane output: lane_out_valid[i] = non-empty[i] && !(eng_in_valid && g==i && eng_in_ready). The granted lane is withheld from its output only when the engine actually takes the token, so a token is never lost or duplicated. lane_out_data[i] = head[i].
- Pop rule: pop[i] = engine transfer from i, or lane_out transfer on i. These are mutually exclusive by construction.
- Occupancy counters: one per cc_id c, width FIFO_DEPTH_BITS+clog2(NUM_LANES)+1.
  - Next value = cnt + (number of writes with cc_id c this cycle) − (number of pops with cc_id c this cycle).
  - Multiple lanes may push and pop the same cc_id in one cycle.
  - Counts never underflow or overflow by construction; assertions check both.
- Status outputs (all combinational from registered state plus inputs):
  - elaborating_chars[c] = (cnt[c]!=0) || engine_elaborating[c].
  - station_running = any non-empty || engine_running.
  - station_full = all lanes full.
- Reset (rst==0), including mid-operation:
  - FIFOs emptied, counters = 0, gp = 0; in-flight tokens are dropped.
  - All ready and valid outputs are 0 while rst==0.
  - eng_in_data and lane_out_data are don't-care while their valid is low.

Test Plan:
- Reset, then one token {cc=1,pc=0x05} on lane 0, eng_in_ready=1 -> eng_in_valid high one cycle after the write with data 0x105; lane_out_valid[0] stays 0; elaborating_chars=4'b0010 for one cycle, then 0.
- Same token with eng_in_ready=0 -> lane_out_valid[0]=1 with data 0x105; pop on lane_out_ready; gp unchanged (0).
- Heads present on both lanes, eng_in_ready=1 for 4 cycles, continuous refill -> engine receives lane order 0,1,0,1.
- Lane 0 holds 3 tokens, lane 1 holds 1, eng_out_valid with 0x2AA -> token written to lane 1; lane_in_ready[1]=0 that cycle; lane 1 count becomes 2.
- Fill every lane to 4 with lane_out_ready=0 and eng_in_ready=0 -> station_full=1, all lane_in_ready=0, eng_out_ready=0; then one lane_out pop -> that lane's ready returns 1 in the same cycle.
- Assert rst=0 mid-stream with 5 tokens queued -> next cycle all counts 0, elaborating_chars = engine_elaborating, all valids 0, gp=0.
